// File: rtl/mmcm_ps_pkg.sv
// Shared definitions for the MMCM dynamic phase-shift sequencer:
// the FSM state type and default widths / psdone timeout.
package mmcm_ps_pkg;

   localparam int STEP_W_DEF  = 16;
   localparam int POS_W_DEF   = 16;
   localparam int TIMEOUT_DEF = 1023;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      FINISH
   } state_t;

endpackage

// File: rtl/mmcm_ps_sequencer.sv
// Steps the MMCM phase-shift port one psen/psdone handshake at a time and tracks the offset.
// Optional psdone watchdog is enabled by defining PS_TIMEOUT_EN.
module mmcm_ps_sequencer
   import mmcm_ps_pkg::*;
#(
   parameter int STEP_W  = STEP_W_DEF,
   parameter int POS_W   = POS_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              psclk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic              locked,
   output logic              psen,
   output logic              psincdec,
   input  logic              psdone,
   output logic [POS_W-1:0]  pos,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t            state;
   state_t            next_state;
   logic              dir;
   logic              dir_next;
   logic [STEP_W-1:0] rem;
   logic [STEP_W-1:0] abs_steps;
   logic              accept;
   logic              abort;
   logic              step_done;
   logic              timeout;

   // Magnitude as unsigned; the most negative command maps to 2^(STEP_W-1).
   assign abs_steps = cmd_steps[STEP_W-1] ? (~cmd_steps + STEP_W'(1)) : cmd_steps;
   assign cmd_ready = (state == IDLE) && locked;
   assign dir_next  = accept ? ~cmd_steps[STEP_W-1] : dir;

`ifdef PS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge psclk) begin
      if (reset || state != WAIT) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   // Fires on the TIMEOUT-th consecutive WAIT cycle without psdone.
   assign timeout = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign timeout        = 1'b0;
`endif

   always_ff @(posedge psclk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      next_state = state;
      accept     = 1'b0;
      abort      = 1'b0;
      step_done  = 1'b0;
      unique case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept     = 1'b1;
               next_state = (abs_steps == '0) ? FINISH : ISSUE;
            end
         end
         ISSUE: begin
            if (!locked) begin
               abort      = 1'b1;
               next_state = FINISH;
            end else begin
               next_state = WAIT;
            end
         end
         WAIT: begin
            // A psdone coinciding with lock loss still counts before the abort.
            step_done = psdone;
            if (!locked || (!psdone && timeout)) begin
               abort      = 1'b1;
               next_state = FINISH;
            end else if (psdone) begin
               next_state = (rem != '0) ? ISSUE : FINISH;
            end
         end
         FINISH: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: outputs are registered from next_state so each one is valid in the same cycle as the state it reports.
   always_ff @(posedge psclk) begin
      if (reset) begin
         dir      <= 1'b0;
         rem      <= '0;
         pos      <= '0;
         err      <= 1'b0;
         psen     <= 1'b0;
         psincdec <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         psen     <= (next_state == ISSUE);
         psincdec <= (next_state == ISSUE) && dir_next;
         busy     <= (next_state != IDLE);
         done     <= (next_state == FINISH);

         if (accept) begin
            dir <= ~cmd_steps[STEP_W-1];
            rem <= abs_steps;
         end else if (state == ISSUE) begin
            rem <= rem - STEP_W'(1);
         end

         if (accept) begin
            err <= 1'b0;
         end else if (abort) begin
            err <= 1'b1;
         end

         if (step_done) begin
            pos <= dir ? (pos + POS_W'(1)) : (pos - POS_W'(1));
         end
      end
   end

endmodule

// File: doc/mmcm_ps_sequencer.md
# mmcm_ps_sequencer

Drives the MMCM dynamic phase-shift port of the TDC clocking block as its initiator. It accepts a signed step-count command, issues one `psen` pulse per step with the matching `psincdec` direction, and waits for `psdone` before each subsequent step. It tracks the accumulated phase offset and reports completion, lock loss and psdone timeouts. It sits in the `psclk` domain, between the TDC calibration/scan controller and the clock-wizard wrapper.

## Interface
- `STEP_W`, 16: width of the signed step command.
- `POS_W`, 16: width of the signed accumulated-position counter.
- `TIMEOUT`, 1023: maximum `psclk` cycles to wait for `psdone` per step (used only with `PS_TIMEOUT_EN`).

- `psclk`  in  1  sole clock, the phase-shift interface clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command can be accepted (IDLE and `locked`).
- `cmd_steps`  in  STEP_W  signed step count: positive increments, negative decrements.
- `locked`  in  1  MMCM lock status.
- `psen`  out  1  one-cycle phase-shift enable pulse.
- `psincdec`  out  1  direction: 1 increments, 0 decrements. Valid while `psen` is high.
- `psdone`  in  1  MMCM step-complete pulse.
- `pos`  out  POS_W  signed accumulated step offset since reset.
- `busy`  out  1  a command is in progress.
- `done`  out  1  one-cycle pulse when a command ends, whether it completed normally or aborted.
- `err`  out  1  sticky abort flag, cleared when the next command is accepted.

## Operation
- All outputs are registered. Reset value of every output is 0, except `cmd_ready`, which is combinational: `cmd_ready = (state==IDLE) & locked`.
- States:
  - IDLE
  - ISSUE
  - WAIT
  - FINISH
- IDLE:
  - The accept condition is `cmd_valid & cmd_ready`.
  - On accept, latch `dir = ~cmd_steps[MSB]` and `rem = |cmd_steps|` as an unsigned STEP_W value. `-2^(STEP_W-1)` gives `rem = 2^(STEP_W-1)`, which is correct.
  - On accept, clear `err`.
  - If `rem == 0`, go to FINISH. Otherwise go to ISSUE.
- ISSUE:
  - Drive `psen=1` and `psincdec=dir` for exactly one cycle.
  - Decrement `rem`, then go to WAIT.
- WAIT:
  - On `psdone`, update `pos` by ±1 (two's-complement wrap, no saturation).
  - After that `psdone`, go to ISSUE if `rem != 0`, otherwise go to FINISH.
- FINISH: pulse `done` for one cycle, then return to IDLE.
- Abort: `locked==0` in ISSUE or WAIT (or a timeout) does the following:
  - set `err=1`
  - go to FINISH, so `done` still pulses once
  - leave the remaining steps unissued
  - keep `pos` reflecting only completed steps
- `psdone` arriving in IDLE, ISSUE or FINISH is ignored, with no effect on `pos`.
- If `psdone` and lock loss occur in the same WAIT cycle, `pos` updates first and then the command aborts.
- `busy = (state != IDLE)`.
- Reset mid-command returns to IDLE and clears `pos`, `rem`, `err`, `psen`. An outstanding MMCM step is not tracked.

## Timing
- Command accepted at cycle T: `psen` is high at T+1 and `busy` is high from T+1.
- `psdone` sampled at cycle N: the next `psen` is at N+1, or the `done` pulse is at N+1 for the last step.
- Minimum psen-to-psen spacing is 2 cycles. `psen` is never re-asserted before `psdone` of the previous step.
- A zero-step command gives `done` at T+1 with no `psen`.
- `pos` updates in the cycle after `psdone` is sampled.
- `done` and the final `pos` value become visible together.

## Configuration
- `PS_TIMEOUT_EN` defined:
  - A wait counter is cleared on entry to WAIT and incremented each WAIT cycle.
  - When the counter reaches `TIMEOUT` without `psdone`, the command aborts (`err=1`, FINISH).
- `PS_TIMEOUT_EN` not defined:
  - There is no counter, and WAIT holds indefinitely until `psdone` or lock loss.
  - The `TIMEOUT` parameter is unused.

## Structure
- Shared package `mmcm_ps_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/FINISH)
  - default `STEP_W`/`POS_W`/`TIMEOUT` constants
- No sub-module. The FSM, step counter, position accumulator and optional watchdog live in a single module.

## Test plan
- `cmd_steps=+3`, `psdone` returned 12 cycles after each `psen`:
  - 3 `psen` pulses with `psincdec=1`
  - `pos` goes 0→3
  - one `done` pulse, `err=0`
- `cmd_steps=-2` from `pos=3`:
  - 2 pulses with `psincdec=0`
  - `pos=1`, `done` pulse, `err=0`
- `cmd_steps=0`: no `psen`, `done` at T+1, `pos` unchanged.
- `cmd_steps=+5`, `locked` dropped after the 2nd `psdone`:
  - `pos=+2`, `err=1`, one `done` pulse
  - `cmd_ready` stays 0 until `locked` returns
- With `PS_TIMEOUT_EN` and `TIMEOUT=20`, `cmd_steps=+1` and `psdone` withheld:
  - abort 20 cycles after entering WAIT
  - `err=1`, `pos` unchanged
  - a spurious `psdone` afterwards in IDLE is ignored
- `pos=32767` (`POS_W=16`), `cmd_steps=+1`: `pos` wraps to -32768.
